broccoli_clkgen: RTL and testbench
==================================

BROCCOLI_CLKGEN -- requirements
Module: broccoli_clkgen

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of generated clock-enable channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8: width of the divide and phase fields.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16: cycles spent in LOCKING before lock (>=1).
REQ-004 SHALL have parameter DIV_RESET_M1, default 3: reset divide-minus-one of every channel (divide-by-4).
REQ-005 SHALL have port clock, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port pwrdwn, input, 1: power-down request; stops all channels while high.
REQ-008 SHALL have port cfg_valid, input, 1: configuration write request.
REQ-009 SHALL have port cfg_ready, output, 1: configuration write accepted when high with cfg_valid.
REQ-010 SHALL have port cfg_chan, input, max(1,clog2(CHANNELS)): target channel.
REQ-011 SHALL have port cfg_div_m1, input, DIV_W: new divide-minus-one (0 = strobe every cycle).
REQ-012 SHALL have port cfg_phase, input, DIV_W: new start phase.
REQ-013 SHALL have port strobe, output, CHANNELS: per-channel one-cycle clock enables.
REQ-014 SHALL have port clk_lvl, output, CHANNELS: per-channel 50%-duty level (see Configuration).
REQ-015 SHALL have port locked, output, 1: high only in RUNNING.

Function
REQ-016 SHALL implement states IDLE, LOCKING, RUNNING; locked = (state == RUNNING), registered.
REQ-017 IDLE -> LOCKING on the first edge with pwrdwn low; lock counter cleared to 0.
REQ-018 LOCKING: lock counter increments each cycle; at value LOCK_CYCLES-1 -> RUNNING next edge.
REQ-019 Any state -> IDLE on the edge where pwrdwn is high; pwrdwn has priority over all other events.
REQ-020 cfg_ready SHALL equal !pwrdwn (combinational); a write occurs when cfg_valid && cfg_ready.
REQ-021 Accepted write with cfg_chan < CHANNELS: update that channel's div_m1/phase registers; LOCKING or RUNNING -> LOCKING with lock counter cleared; locked falls next edge.
REQ-022 Accepted write with cfg_chan >= CHANNELS: ignored, no state change.
REQ-023 On entry to RUNNING each channel counter SHALL load min(phase, div_m1).
REQ-024 RUNNING: counter increments each cycle, wraps from div_m1 to 0.
REQ-025 strobe[i] = RUNNING && counter[i] == div_m1[i], combinational from registered state; low in IDLE/LOCKING.
REQ-026 Counters SHALL hold their value outside RUNNING; arithmetic is DIV_W-bit unsigned, no overflow beyond div_m1.

Reset
REQ-027 aresetn low SHALL immediately force: state IDLE, lock counter 0, all counters 0, div_m1 = DIV_RESET_M1, phase = 0, locked 0, strobe 0, clk_lvl 0.
REQ-028 Reset mid-operation SHALL discard any programmed configuration.

Configuration
REQ-029 Macro BROCCOLI_CLKGEN_LEVEL_EN defined: clk_lvl[i] SHALL toggle on each cycle strobe[i] is high (period 2*(div_m1+1)), clear to 0 when leaving RUNNING.
REQ-030 Macro undefined: clk_lvl SHALL be tied to 0 and no toggle flops synthesised.

Structure
REQ-031 Package broccoli_clkgen_pkg SHALL hold the state enum and the default DIV_W/LOCK_CYCLES/DIV_RESET_M1 constants.
REQ-032 Per-channel counter, strobe compare and level toggle SHALL be sub-module broccoli_clkgen_channel, instantiated CHANNELS times; state machine stays in the top.

Verification
REQ-033 Defaults, release aresetn with pwrdwn=0 -> locked rises on edge 17 after release; each strobe first high in RUNNING cycle 3, then every 4 cycles.
REQ-034 Write chan 1, div_m1=6, phase=2 while RUNNING -> locked low next edge, high 16 cycles later; strobe[1] on RUNNING cycle 4, then every 7; channels 0/2 unchanged at divide-by-4.
REQ-035 Write chan 0, div_m1=3, phase=9 -> phase clamped; strobe[0] high in first RUNNING cycle.
REQ-036 Assert pwrdwn mid-RUNNING together with cfg_valid -> cfg_ready 0, write dropped, IDLE next edge, strobes 0; release -> relock after 17 edges.
REQ-037 Write cfg_chan=3 with CHANNELS=3 -> accepted, locked stays 1, no strobe timing change.
REQ-038 With BROCCOLI_CLKGEN_LEVEL_EN, div_m1=0 -> clk_lvl toggles every cycle; pull aresetn low mid-run -> all outputs 0 in same cycle, divides back to 4.

Source files
------------

// File: rtl/broccoli_clkgen_pkg.sv
// ============================================================================
// broccoli_clkgen_pkg : shared state encoding and default constants
// Rev 1.0
// ============================================================================
`default_nettype none

package broccoli_clkgen_pkg;

    localparam int c_def_div_w        = 8;
    localparam int c_def_lock_cycles  = 16;
    localparam int c_def_div_reset_m1 = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKING = 2'd1,
        ST_RUNNING = 2'd2
    } clkgen_state_t;

    // Width able to hold values 0..n-1, never narrower than one bit.
    function automatic int f_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/broccoli_clkgen_channel.sv
// ============================================================================
// broccoli_clkgen_channel : one divider channel (counter, strobe, level)
// Level toggle present only with BROCCOLI_CLKGEN_LEVEL_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module broccoli_clkgen_channel
    import broccoli_clkgen_pkg::*;
#(
    parameter int DIV_W        = c_def_div_w,
    parameter int DIV_RESET_M1 = c_def_div_reset_m1
) (
    input  logic             clock,
    input  logic             aresetn,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_div_m1,
    input  logic [DIV_W-1:0] i_phase,
    input  logic             i_load,
    input  logic             i_run,
    input  logic             i_run_next,
    output logic             o_strobe,
    output logic             o_lvl
);

    logic [DIV_W-1:0] r_div_m1;
    logic [DIV_W-1:0] r_phase;
    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            r_div_m1 <= DIV_W'(DIV_RESET_M1);
            r_phase  <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_wr) begin
                r_div_m1 <= i_div_m1;
                r_phase  <= i_phase;
            end
            // A phase beyond the divide range starts the channel on its strobe.
            if (i_load) begin
                r_cnt <= (r_phase < r_div_m1) ? r_phase : r_div_m1;
            end else if (i_run) begin
                r_cnt <= (r_cnt == r_div_m1) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign o_strobe = i_run && (r_cnt == r_div_m1);

`ifdef BROCCOLI_CLKGEN_LEVEL_EN
    logic r_lvl;

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            r_lvl <= 1'b0;
        end else if (!i_run_next) begin
            r_lvl <= 1'b0;
        end else if (o_strobe) begin
            r_lvl <= ~r_lvl;
        end
    end

    assign o_lvl = r_lvl;
`else
    logic w_unused_run_next;
    assign w_unused_run_next = i_run_next;
    assign o_lvl             = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/broccoli_clkgen.sv
// ============================================================================
// broccoli_clkgen : lock state machine driving CHANNELS clock-enable dividers
// Optional 50% level outputs via BROCCOLI_CLKGEN_LEVEL_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module broccoli_clkgen
    import broccoli_clkgen_pkg::*;
#(
    parameter int CHANNELS     = 3,
    parameter int DIV_W        = c_def_div_w,
    parameter int LOCK_CYCLES  = c_def_lock_cycles,
    parameter int DIV_RESET_M1 = c_def_div_reset_m1
) (
    input  logic                                        clock,
    input  logic                                        aresetn,
    input  logic                                        pwrdwn,
    input  logic                                        cfg_valid,
    output logic                                        cfg_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
    input  logic [DIV_W-1:0]                            cfg_div_m1,
    input  logic [DIV_W-1:0]                            cfg_phase,
    output logic [CHANNELS-1:0]                         strobe,
    output logic [CHANNELS-1:0]                         clk_lvl,
    output logic                                        locked
);

    localparam int C_SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int C_LK_W  = f_cnt_w(LOCK_CYCLES);

    clkgen_state_t     r_state;
    logic [C_LK_W-1:0] r_lock_cnt;
    logic              r_locked;

    logic              w_wr;
    logic              w_lock_done;
    logic              w_run;
    logic              w_run_next;

    assign cfg_ready = !pwrdwn;
    assign w_wr      = cfg_valid && !pwrdwn && (int'(cfg_chan) < CHANNELS);

    // Power-down outranks a write, which outranks lock progress.
    assign w_lock_done = (r_state == ST_LOCKING) && !pwrdwn && !w_wr &&
                         (r_lock_cnt == C_LK_W'(LOCK_CYCLES - 1));
    assign w_run       = (r_state == ST_RUNNING);
    assign w_run_next  = !pwrdwn && !w_wr && (w_run || w_lock_done);

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (pwrdwn) begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
        end else if (w_wr) begin
            r_state    <= ST_LOCKING;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_LOCKING;
                    r_lock_cnt <= '0;
                end
                ST_LOCKING: begin
                    if (w_lock_done) begin
                        r_state  <= ST_RUNNING;
                        r_locked <= 1'b1;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                ST_RUNNING: begin
                    r_locked <= 1'b1;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign locked = r_locked;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            broccoli_clkgen_channel #(
                .DIV_W        (DIV_W),
                .DIV_RESET_M1 (DIV_RESET_M1)
            ) u_chan (
                .clock      (clock),
                .aresetn    (aresetn),
                .i_wr       (w_wr && (cfg_chan == C_SEL_W'(gi))),
                .i_div_m1   (cfg_div_m1),
                .i_phase    (cfg_phase),
                .i_load     (w_lock_done),
                .i_run      (w_run),
                .i_run_next (w_run_next),
                .o_strobe   (strobe[gi]),
                .o_lvl      (clk_lvl[gi])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_broccoli_clkgen.sv
// ============================================================================
// tb_broccoli_clkgen : directed stimulus, per-cycle check against a timing model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_broccoli_clkgen;

    localparam int CH   = 3;
    localparam int LOCK = 16;

    logic       clock      = 1'b0;
    logic       aresetn    = 1'b0;
    logic       pwrdwn     = 1'b0;
    logic       cfg_valid  = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_chan   = 2'd0;
    logic [7:0] cfg_div_m1 = 8'd0;
    logic [7:0] cfg_phase  = 8'd0;
    logic [2:0] strobe;
    logic [2:0] clk_lvl;
    logic       locked;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    broccoli_clkgen #(
        .CHANNELS     (CH),
        .DIV_W        (8),
        .LOCK_CYCLES  (LOCK),
        .DIV_RESET_M1 (3)
    ) dut (
        .clock      (clock),
        .aresetn    (aresetn),
        .pwrdwn     (pwrdwn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_div_m1 (cfg_div_m1),
        .cfg_phase  (cfg_phase),
        .strobe     (strobe),
        .clk_lvl    (clk_lvl),
        .locked     (locked)
    );

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: edges elapsed since the lock sequence began; running once LOCK edges pass.
    int m_active = 0;
    int m_since  = 0;
    int m_div[CH] = '{3, 3, 3};
    int m_ph[CH]  = '{0, 0, 0};

    always @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            m_active = 0;
            m_since  = 0;
            for (int i = 0; i < CH; i++) begin
                m_div[i] = 3;
                m_ph[i]  = 0;
            end
        end else if (pwrdwn) begin
            m_active = 0;
        end else if (cfg_valid && int'(cfg_chan) < CH) begin
            m_div[cfg_chan] = int'(cfg_div_m1);
            m_ph[cfg_chan]  = int'(cfg_phase);
            m_active = 1;
            m_since  = 0;
        end else if (m_active == 0) begin
            m_active = 1;
            m_since  = 0;
        end else begin
            m_since++;
        end
    end

    always @(negedge clock) begin
        logic [2:0] es;
        logic [2:0] el;
        logic       run;
        int         k;
        int         s;
        int         d;
        run = (m_active != 0) && (m_since >= LOCK);
        es  = '0;
        el  = '0;
        if (run) begin
            k = m_since - LOCK;
            for (int i = 0; i < CH; i++) begin
                d = m_div[i];
                s = (m_ph[i] < d) ? m_ph[i] : d;
                es[i] = (((k + s) % (d + 1)) == d);
`ifdef BROCCOLI_CLKGEN_LEVEL_EN
                el[i] = ((((k + s) / (d + 1)) % 2) == 1);
`endif
            end
        end
        check("model_locked", {7'd0, locked}, {7'd0, run});
        check("model_strobe", {5'd0, strobe}, {5'd0, es});
        check("model_clk_lvl", {5'd0, clk_lvl}, {5'd0, el});
        check("model_cfg_ready", {7'd0, cfg_ready}, {7'd0, !pwrdwn});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    // Write, then walk through the full relock and land on RUNNING cycle 0.
    task automatic relock_wr(input logic [1:0] ch, input logic [7:0] dv, input logic [7:0] ph);
        cfg_valid  = 1'b1;
        cfg_chan   = ch;
        cfg_div_m1 = dv;
        cfg_phase  = ph;
        step(1);
        cfg_valid = 1'b0;
        check("wr_unlock", {7'd0, locked}, 8'd0);
        step(15);
        check("wr_lock_e15", {7'd0, locked}, 8'd0);
        step(1);
        check("wr_lock_e16", {7'd0, locked}, 8'd1);
    endtask

    initial begin
        step(2);
        check("rst_locked", {7'd0, locked}, 8'd0);
        check("rst_strobe", {5'd0, strobe}, 8'd0);
        aresetn = 1'b1;
        step(16);
        check("lock_e16", {7'd0, locked}, 8'd0);
        step(1);
        check("lock_e17", {7'd0, locked}, 8'd1);
        check("run_c0", {5'd0, strobe}, 8'h0);
        step(3);
        check("run_c3", {5'd0, strobe}, 8'h7);
        step(1);
        check("run_c4", {5'd0, strobe}, 8'h0);
        step(3);
        check("run_c7", {5'd0, strobe}, 8'h7);

        relock_wr(2'd1, 8'd6, 8'd2);
        step(3);
        check("div7_c3", {5'd0, strobe}, 8'h5);
        step(1);
        check("div7_c4", {5'd0, strobe}, 8'h2);
        step(7);
        check("div7_c11", {5'd0, strobe}, 8'h7);

        relock_wr(2'd0, 8'd3, 8'd9);
        check("clamp_c0", {5'd0, strobe}, 8'h1);

        step(2);
        cfg_valid = 1'b1;
        cfg_chan  = 2'd3;
        cfg_div_m1 = 8'd1;
        cfg_phase  = 8'd0;
        #1;
        check("oor_ready", {7'd0, cfg_ready}, 8'd1);
        step(1);
        cfg_valid = 1'b0;
        check("oor_locked", {7'd0, locked}, 8'd1);
        check("oor_c3", {5'd0, strobe}, 8'h4);
        step(1);
        check("oor_c4", {5'd0, strobe}, 8'h3);

        pwrdwn    = 1'b1;
        cfg_valid = 1'b1;
        cfg_chan  = 2'd2;
        cfg_div_m1 = 8'd1;
        #1;
        check("pd_ready", {7'd0, cfg_ready}, 8'd0);
        step(1);
        cfg_valid = 1'b0;
        check("pd_locked", {7'd0, locked}, 8'd0);
        check("pd_strobe", {5'd0, strobe}, 8'h0);
        step(2);
        pwrdwn = 1'b0;
        step(16);
        check("pd_e16", {7'd0, locked}, 8'd0);
        step(1);
        check("pd_e17", {7'd0, locked}, 8'd1);
        check("pd_c0", {5'd0, strobe}, 8'h1);
        step(3);
        check("pd_c3", {5'd0, strobe}, 8'h4);

        relock_wr(2'd2, 8'd0, 8'd0);
        check("div1_c0", {5'd0, strobe}, 8'h5);
        step(1);
        check("div1_c1", {5'd0, strobe}, 8'h4);
`ifdef BROCCOLI_CLKGEN_LEVEL_EN
        check("lvl_c1", {5'd0, clk_lvl}, 8'h5);
`else
        check("lvl_c1", {5'd0, clk_lvl}, 8'h0);
`endif
        step(1);
        aresetn = 1'b0;
        #1;
        check("arst_locked", {7'd0, locked}, 8'd0);
        check("arst_strobe", {5'd0, strobe}, 8'h0);
        check("arst_lvl", {5'd0, clk_lvl}, 8'h0);
        step(1);
        aresetn = 1'b1;
        step(17);
        check("arst_relock", {7'd0, locked}, 8'd1);
        step(3);
        check("arst_c3", {5'd0, strobe}, 8'h7);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
